// File: rtl/play_seq_ctrl.sv
`default_nettype none
// ==================================================================
// Module  : play_seq_ctrl
// Purpose : SRAM playback sequencer for slow/fast play; feeds the
//           interpolator one sample pair per stored-sample step.
//           Define PLAY_LOOP_EN to wrap playback instead of stopping.
// Rev     : 1.0  initial release
// ==================================================================
module play_seq_ctrl #(
   parameter int ADDR_W = 20,
   parameter int RD_LAT = 1
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_start,
   input  logic              i_pause,
   input  logic              i_stop,
   input  logic              i_fast,
   input  logic              i_interp,
   input  logic [3:0]        i_speed,
   input  logic [ADDR_W-1:0] i_end_addr,
   input  logic              i_sample_req,
   output logic [ADDR_W-1:0] o_sram_addr,
   output logic              o_sram_rd,
   input  logic [15:0]       i_sram_data,
   output logic [15:0]       o_data1,
   output logic [15:0]       o_data2,
   output logic [2:0]        o_count_inter,
   output logic [3:0]        o_speed,
   output logic              o_mode,
   output logic              o_load,
   output logic              o_busy,
   output logic              o_underrun,
   output logic [ADDR_W-1:0] o_cur_addr
);

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH1 = 3'd1,
      S_FETCH2 = 3'd2,
      S_PLAY   = 3'd3,
      S_PAUSED = 3'd4
   } state_t;

   localparam logic [1:0] LAT_INIT = 2'(RD_LAT);

   state_t            state_q, state_d, resume_q, resume_d, fetch_nxt;
   logic [ADDR_W-1:0] cur_addr_q, cur_addr_d, sram_addr_q, sram_addr_d;
   logic [15:0]       data1_q, data1_d, data2_q, data2_d;
   logic [2:0]        count_q, count_d;
   logic [3:0]        speed_q, speed_d, n_q, n_d;
   logic              mode_q, mode_d, fast_q, fast_d;
   logic              pending_q, pending_d, underrun_q, underrun_d;
   logic              pause_pend_q, pause_pend_d, req_sent_q, req_sent_d;
   logic              rd_q, rd_d;
   logic [1:0]        lat_q, lat_d;
   logic              load, relatch;

   logic [3:0]        spd_clamp, n_new;
   logic [ADDR_W:0]   end_ext, addr_inc, addr_fast;
   logic [ADDR_W-1:0] fetch2_addr;
   logic              outstanding, data_vld, serve;

   assign spd_clamp   = (i_speed > 4'd7) ? 4'd7 : i_speed;
   assign n_new       = 4'd8 - spd_clamp;
   assign end_ext     = {1'b0, i_end_addr};
   assign addr_inc    = {1'b0, cur_addr_q} + (ADDR_W+1)'(1);
   assign addr_fast   = {1'b0, cur_addr_q} + {{(ADDR_W-3){1'b0}}, n_q};
   assign fetch2_addr = (addr_inc > end_ext) ? i_end_addr : addr_inc[ADDR_W-1:0];
   // lat_q counts down the SRAM latency; data is on the bus when it reaches 1
   assign outstanding = rd_q | (lat_q != 2'd0);
   assign data_vld    = (lat_q == 2'd1) & req_sent_q;
   assign serve       = i_sample_req | pending_q;
   assign fetch_nxt   = (state_q == S_FETCH1) ? S_FETCH2 : S_PLAY;

`ifdef PLAY_LOOP_EN
   function automatic logic [ADDR_W:0] wrap_len(input logic [ADDR_W:0] a,
                                                input logic [ADDR_W:0] m);
      logic [ADDR_W:0] r;
      r = a;
      for (int k = 0; k < 8; k++) begin
         if (r >= m) r = r - m;
      end
      return r;
   endfunction

   logic [ADDR_W:0] addr_wrap;
   assign addr_wrap = wrap_len(addr_fast, end_ext + (ADDR_W+1)'(1));
`endif

   always_comb begin
      state_d      = state_q;
      resume_d     = resume_q;
      cur_addr_d   = cur_addr_q;
      sram_addr_d  = sram_addr_q;
      data1_d      = data1_q;
      data2_d      = data2_q;
      count_d      = count_q;
      pending_d    = pending_q;
      underrun_d   = underrun_q;
      pause_pend_d = pause_pend_q;
      req_sent_d   = req_sent_q;
      rd_d         = 1'b0;
      lat_d        = rd_q ? LAT_INIT : ((lat_q != 2'd0) ? lat_q - 2'd1 : 2'd0);
      load         = 1'b0;
      relatch      = 1'b0;

      if (i_stop) begin
         state_d      = S_IDLE;
         pending_d    = 1'b0;
         pause_pend_d = 1'b0;
         req_sent_d   = 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (i_start) begin
                  underrun_d = 1'b0;
                  if (i_end_addr != '0) begin
                     state_d    = S_FETCH1;
                     cur_addr_d = '0;
                     count_d    = 3'd0;
                     pending_d  = 1'b0;
                     relatch    = 1'b1;
                  end
               end
            end
            S_FETCH1, S_FETCH2: begin
               if (i_pause) pause_pend_d = 1'b1;
               if (i_sample_req) begin
                  if (pending_q) underrun_d = 1'b1;
                  else           pending_d  = 1'b1;
               end
               if (!req_sent_q && !outstanding) begin
                  rd_d        = 1'b1;
                  sram_addr_d = (state_q == S_FETCH1) ? cur_addr_q : fetch2_addr;
                  req_sent_d  = 1'b1;
               end
               if (data_vld) begin
                  req_sent_d = 1'b0;
                  if (state_q == S_FETCH1) data1_d = i_sram_data;
                  else                     data2_d = i_sram_data;
                  if (pause_pend_q || i_pause) begin
                     state_d      = S_PAUSED;
                     resume_d     = fetch_nxt;
                     pause_pend_d = 1'b0;
                  end else begin
                     state_d = fetch_nxt;
                  end
               end
            end
            S_PLAY: begin
               if (i_pause) begin
                  state_d  = S_PAUSED;
                  resume_d = S_PLAY;
               end else if (serve) begin
                  load      = 1'b1;
                  // a fresh request arriving while the pending one is served stays queued
                  pending_d = pending_q & i_sample_req;
                  if (fast_q) begin
                     if (addr_fast > end_ext) begin
`ifdef PLAY_LOOP_EN
                        cur_addr_d = addr_wrap[ADDR_W-1:0];
                        state_d    = S_FETCH1;
                        relatch    = 1'b1;
`else
                        state_d    = S_IDLE;
                        pending_d  = 1'b0;
`endif
                     end else begin
                        cur_addr_d = addr_fast[ADDR_W-1:0];
                        state_d    = S_FETCH1;
                        relatch    = 1'b1;
                     end
                  end else if ({1'b0, count_q} < (n_q - 4'd1)) begin
                     count_d = count_q + 3'd1;
                  end else begin
                     count_d = 3'd0;
                     if (addr_inc > end_ext) begin
`ifdef PLAY_LOOP_EN
                        cur_addr_d = '0;
                        state_d    = S_FETCH1;
                        relatch    = 1'b1;
`else
                        state_d    = S_IDLE;
                        pending_d  = 1'b0;
`endif
                     end else begin
                        cur_addr_d = addr_inc[ADDR_W-1:0];
                        data1_d    = data2_q;
                        state_d    = S_FETCH2;
                        relatch    = 1'b1;
                     end
                  end
               end
            end
            S_PAUSED: begin
               if (i_start) state_d = resume_q;
            end
            default: state_d = S_IDLE;
         endcase
      end

      speed_d = relatch ? spd_clamp : speed_q;
      n_d     = relatch ? n_new : n_q;
      mode_d  = relatch ? (i_interp & ~i_fast) : mode_q;
      fast_d  = relatch ? i_fast : fast_q;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q      <= S_IDLE;
         resume_q     <= S_PLAY;
         cur_addr_q   <= '0;
         sram_addr_q  <= '0;
         data1_q      <= '0;
         data2_q      <= '0;
         count_q      <= '0;
         speed_q      <= '0;
         n_q          <= 4'd8;
         mode_q       <= 1'b0;
         fast_q       <= 1'b0;
         pending_q    <= 1'b0;
         underrun_q   <= 1'b0;
         pause_pend_q <= 1'b0;
         req_sent_q   <= 1'b0;
         rd_q         <= 1'b0;
         lat_q        <= '0;
      end else begin
         state_q      <= state_d;
         resume_q     <= resume_d;
         cur_addr_q   <= cur_addr_d;
         sram_addr_q  <= sram_addr_d;
         data1_q      <= data1_d;
         data2_q      <= data2_d;
         count_q      <= count_d;
         speed_q      <= speed_d;
         n_q          <= n_d;
         mode_q       <= mode_d;
         fast_q       <= fast_d;
         pending_q    <= pending_d;
         underrun_q   <= underrun_d;
         pause_pend_q <= pause_pend_d;
         req_sent_q   <= req_sent_d;
         rd_q         <= rd_d;
         lat_q        <= lat_d;
      end
   end

   assign o_sram_addr   = sram_addr_q;
   assign o_sram_rd     = rd_q;
   assign o_data1       = data1_q;
   assign o_data2       = data2_q;
   assign o_count_inter = count_q;
   assign o_speed       = speed_q;
   assign o_mode        = mode_q;
   assign o_load        = load;
   assign o_busy        = (state_q != S_IDLE);
   assign o_underrun    = underrun_q;
   assign o_cur_addr    = cur_addr_q;

endmodule
`default_nettype wire

// File: tb/tb_play_seq_ctrl.sv
`default_nettype none
// ==================================================================
// Module  : tb_play_seq_ctrl
// Purpose : Directed scoreboard bench for play_seq_ctrl with an SRAM
//           model of fixed read latency. Honours PLAY_LOOP_EN.
// Rev     : 1.0  initial release
// ==================================================================
module tb_play_seq_ctrl;

   localparam int ADDR_W = 20;
   localparam int RD_LAT = 3;

   typedef logic [59:0] exp_t;

   logic              clk = 1'b0;
   logic              rst_n, start, pause, stop, fast, interp, sample_req;
   logic [3:0]        speed;
   logic [ADDR_W-1:0] end_addr, sram_addr, cur_addr;
   logic              sram_rd, mode, load, busy, underrun;
   logic [15:0]       sram_data, data1, data2;
   logic [2:0]        count_inter;
   logic [3:0]        speed_o;

   int   checks = 0;
   int   errors = 0;
   int   loads  = 0;
   exp_t sb[$];

   logic [15:0]       mem [0:63];
   logic [2:0]        pv = 3'b000;
   logic [ADDR_W-1:0] pa0, pa1, pa2;

   always #5 clk = ~clk;

   play_seq_ctrl #(.ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) u_dut (
      .i_clk        (clk),
      .i_rst_n      (rst_n),
      .i_start      (start),
      .i_pause      (pause),
      .i_stop       (stop),
      .i_fast       (fast),
      .i_interp     (interp),
      .i_speed      (speed),
      .i_end_addr   (end_addr),
      .i_sample_req (sample_req),
      .o_sram_addr  (sram_addr),
      .o_sram_rd    (sram_rd),
      .i_sram_data  (sram_data),
      .o_data1      (data1),
      .o_data2      (data2),
      .o_count_inter(count_inter),
      .o_speed      (speed_o),
      .o_mode       (mode),
      .o_load       (load),
      .o_busy       (busy),
      .o_underrun   (underrun),
      .o_cur_addr   (cur_addr)
   );

   // Data appears exactly RD_LAT cycles after the read strobe, garbage otherwise
   always @(posedge clk) begin
      pv  <= {pv[1:0], sram_rd};
      pa0 <= sram_addr;
      pa1 <= pa0;
      pa2 <= pa1;
   end
   assign sram_data = pv[2] ? mem[pa2[5:0]] : 16'hDEAD;

   function automatic exp_t mk(input int s, input int c, input int spd, input int m, input int e);
      int s2;
      s2 = (s + 1 > e) ? e : s + 1;
      return {mem[s], mem[s2], 3'(c), 4'(spd), 1'(m), 20'(s)};
   endfunction

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic pulse_start(); start = 1'b1; tick(1); start = 1'b0; endtask
   task automatic pulse_stop();  stop  = 1'b1; tick(1); stop  = 1'b0; endtask
   task automatic pulse_pause(); pause = 1'b1; tick(1); pause = 1'b0; endtask
   task automatic pulse_req();   sample_req = 1'b1; tick(1); sample_req = 1'b0; endtask

   initial begin
      exp_t obs_v, exp_v;
      for (int i = 0; i < 64; i++) mem[i] = 16'((i + 1) * 100);
      rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0; sample_req = 1'b0;
      fast = 1'b0; interp = 1'b0; speed = 4'd0; end_addr = '0;

      fork
         forever begin
            @(negedge clk);
            if (rst_n && sram_rd) begin
               checks++;
               assert (pv == 3'b000) else begin
                  errors++;
                  $error("FAIL rd_overlap observed=%b expected=000", pv);
               end
            end
            if (rst_n && load) begin
               loads++;
               checks++;
               obs_v = {data1, data2, count_inter, speed_o, mode, cur_addr};
               assert (sb.size() != 0) else begin
                  errors++;
                  $error("FAIL unexpected_load observed=%h expected=none", obs_v);
               end
               if (sb.size() != 0) begin
                  exp_v = sb.pop_front();
                  checks++;
                  assert (obs_v === exp_v) else begin
                     errors++;
                     $error("FAIL load_%0d observed=%h expected=%h", loads, obs_v, exp_v);
                  end
               end
            end
         end
      join_none

      tick(3);
      chk("rst_busy", busy, 0);
      chk("rst_load", load, 0);
      chk("rst_rd", sram_rd, 0);
      chk("rst_underrun", underrun, 0);
      chk("rst_cur_addr", cur_addr, 0);
      chk("rst_data1", data1, 0);
      chk("rst_count", count_inter, 0);
      rst_n = 1'b1;
      tick(1);

      // Empty recording never leaves IDLE
      pulse_start();
      tick(2);
      chk("empty_idle", busy, 0);

      // Slow, N=8, linear
      end_addr = 20; interp = 1'b1;
      pulse_start();
      tick(13);
      loads = 0;
      for (int k = 0; k < 24; k++) begin
         sb.push_back(mk(k / 8, k % 8, 0, 1, 20));
         pulse_req();
         tick(7);
      end
      chk("slow_loads", loads, 24);
      chk("slow_sb", sb.size(), 0);
      pulse_stop();
      chk("slow_stop_idle", busy, 0);

      // Fast, N=2, ends past address 9
      end_addr = 9; speed = 4'd6; fast = 1'b1;
      pulse_start();
      tick(13);
      loads = 0;
      for (int k = 0; k < 5; k++) sb.push_back(mk(2 * k, 0, 6, 0, 9));
`ifdef PLAY_LOOP_EN
      sb.push_back(mk(0, 0, 6, 0, 9));
`endif
      for (int k = 0; k < 6; k++) begin
         pulse_req();
         tick(13);
      end
`ifdef PLAY_LOOP_EN
      chk("fast_loads", loads, 6);
      chk("fast_busy", busy, 1);
`else
      chk("fast_loads", loads, 5);
      chk("fast_busy", busy, 0);
`endif
      chk("fast_sb", sb.size(), 0);
      pulse_stop();

      // Two requests while fetching: one served, one lost
      end_addr = 20; speed = 4'd0; fast = 1'b0; interp = 1'b0;
      loads = 0;
      pulse_start();
      tick(6);
      sb.push_back(mk(0, 0, 0, 0, 20));
      pulse_req();
      tick(1);
      pulse_req();
      tick(3);
      chk("ovr_underrun", underrun, 1);
      chk("ovr_loads", loads, 1);
      chk("ovr_count", count_inter, 1);
      chk("ovr_sb", sb.size(), 0);
      pulse_stop();
      chk("ovr_sticky", underrun, 1);
      pulse_start();
      chk("ovr_clear", underrun, 0);

      // Pause at count 3, requests ignored, resume in place
      tick(13);
      loads = 0;
      for (int k = 0; k < 3; k++) begin
         sb.push_back(mk(0, k, 0, 0, 20));
         pulse_req();
         tick(7);
      end
      pulse_pause();
      tick(2);
      chk("pause_busy", busy, 1);
      chk("pause_count", count_inter, 3);
      for (int k = 0; k < 10; k++) begin
         pulse_req();
         tick(1);
      end
      chk("pause_noload", loads, 3);
      chk("pause_data1", data1, 100);
      pulse_start();
      tick(2);
      sb.push_back(mk(0, 3, 0, 0, 20));
      pulse_req();
      tick(2);
      chk("resume_loads", loads, 4);
      chk("resume_sb", sb.size(), 0);
      pulse_stop();

      // Speed change mid-interpolation takes effect at the wrap
      speed = 4'd0; interp = 1'b1;
      pulse_start();
      tick(13);
      loads = 0;
      for (int k = 0; k < 13; k++) begin
         if (k == 2) speed = 4'd4;
         if (k < 8)       sb.push_back(mk(0, k, 0, 1, 20));
         else if (k < 12) sb.push_back(mk(1, k - 8, 4, 1, 20));
         else             sb.push_back(mk(2, 0, 4, 1, 20));
         pulse_req();
         tick(7);
      end
      chk("spd_loads", loads, 13);
      chk("spd_speed", speed_o, 4);
      chk("spd_sb", sb.size(), 0);

      // Stop during FETCH1: late read data must not land in data1
      pulse_stop();
      pulse_start();
      tick(1);
      pulse_stop();
      chk("stopf1_idle", busy, 0);
      chk("stopf1_rd", sram_rd, 0);
      tick(5);
      chk("stopf1_data1", data1, 300);
      pulse_start();
      tick(13);
      sb.push_back(mk(0, 0, 4, 1, 20));
      pulse_req();
      tick(2);
      chk("restart_sb", sb.size(), 0);
      pulse_stop();

      // End of recording in slow mode, N=1
      end_addr = 3; speed = 4'd7;
      pulse_start();
      tick(13);
      loads = 0;
      for (int k = 0; k < 4; k++) begin
         sb.push_back(mk(k, 0, 7, 1, 3));
         pulse_req();
         tick(7);
      end
`ifdef PLAY_LOOP_EN
      chk("end_busy", busy, 1);
      chk("end_wrap_addr", cur_addr, 0);
      tick(5);
      sb.push_back(mk(0, 0, 7, 1, 3));
      pulse_req();
      tick(2);
      chk("end_loads", loads, 5);
`else
      chk("end_busy", busy, 0);
      chk("end_loads", loads, 4);
`endif
      chk("end_sb", sb.size(), 0);
      pulse_stop();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
